// File: rtl/winocnn_pkg.sv
// Shared types and constants for the Winograd CNN weight path.
// A tile is 6x6 signed 12-bit elements packed row-major into one 512-bit word.
package winocnn_pkg;
    localparam int TILE_DIM = 6;
    localparam int ELEM_W   = 12;
    localparam int TILE_N   = TILE_DIM * TILE_DIM;
    localparam int WORD_W   = 512;
    localparam int PACK_W   = TILE_N * ELEM_W;
    localparam int CNT_W    = $clog2(TILE_N + 1);

    typedef logic signed [ELEM_W-1:0] weight_elem_t;
    typedef enum logic [1:0] {IDLE, FILL, COMMIT, DONE} wbuf_state_t;
endpackage

// File: rtl/weight_tile_packer.sv
// Shifts a stream of weight elements into a tile word; element k lands at bits k*ELEM_W.
// 'full' flags the shift that completes the tile, so the loader can commit on the next cycle.
module weight_tile_packer
    import winocnn_pkg::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              clear,
    input  weight_elem_t      elem,
    output logic [DATA_W-1:0] word,
    output logic              full
);
    logic [CNT_W-1:0]  elem_cnt;
    logic [PACK_W-1:0] pack_q;

    always_ff @(posedge clk) begin
        if (reset || clear) elem_cnt <= '0;
        else if (shift_en)  elem_cnt <= elem_cnt + 1'b1;
    end

    // Newest element enters at the top, so after TILE_N shifts element 0 sits in the low bits.
    always_ff @(posedge clk) begin
        if (shift_en) pack_q <= {elem, pack_q[PACK_W-1:ELEM_W]};
    end

    assign full = shift_en && (elem_cnt == CNT_W'(TILE_N - 1));
    assign word = {{(DATA_W - PACK_W){1'b0}}, pack_q};
endmodule

// File: rtl/weight_buffer.sv
// Tile weight SRAM with two independent 1-cycle read ports and a streaming burst loader.
// Reads never stall on the loader; a same-cycle read and commit return the old word.
module weight_buffer
    import winocnn_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start_i,
    input  logic [ADDR_W-1:0] load_base_addr_i,
    input  logic [ADDR_W-1:0] load_count_i,
    input  logic [ELEM_W-1:0] load_elem_i,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    input  logic [ADDR_W-1:0] weight_addr_i_1,
    input  logic [ADDR_W-1:0] weight_addr_i_2,
    input  logic              weight_package_1_valid_i,
    input  logic              weight_package_2_valid_i,
    output logic [DATA_W-1:0] weight_data_o_1,
    output logic [DATA_W-1:0] weight_data_o_2,
    output logic [ADDR_W-1:0] weight_addr_o_1,
    output logic [ADDR_W-1:0] weight_addr_o_2,
    output logic              weight_valid_o_1,
    output logic              weight_valid_o_2
);
    wbuf_state_t       state;
    logic [ADDR_W-1:0] wr_addr, count_q, tile_cnt, tile_next;
    logic [DATA_W-1:0] packed_word;
    logic              tile_full;
    logic              in_range_1, in_range_2, wr_in_range;
    logic [DATA_W-1:0] mem [DEPTH];

    assign tile_next = tile_cnt + 1'b1;

    weight_tile_packer #(.DATA_W(DATA_W)) u_packer (
        .clk      (clk),
        .reset    (reset),
        .shift_en (load_valid_i && load_ready_o),
        .clear    (state == COMMIT),
        .elem     (weight_elem_t'(load_elem_i)),
        .word     (packed_word),
        .full     (tile_full)
    );

    generate
        if (DEPTH < 2**ADDR_W) begin : g_range_check
            assign in_range_1  = int'(weight_addr_i_1) < DEPTH;
            assign in_range_2  = int'(weight_addr_i_2) < DEPTH;
            assign wr_in_range = int'(wr_addr) < DEPTH;
        end else begin : g_full_range
            assign in_range_1  = 1'b1;
            assign in_range_2  = 1'b1;
            assign wr_in_range = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            load_ready_o <= 1'b0;
            load_done_o  <= 1'b0;
            wr_addr      <= '0;
            count_q      <= '0;
            tile_cnt     <= '0;
        end else begin
            load_done_o <= 1'b0;
            unique case (state)
                IDLE: if (load_start_i) begin
                    wr_addr  <= load_base_addr_i;
                    count_q  <= load_count_i;
                    tile_cnt <= '0;
                    if (load_count_i == '0) begin
                        state <= DONE;
                    end else begin
                        state        <= FILL;
                        load_ready_o <= 1'b1;
                    end
                end
                FILL: if (tile_full) begin
                    state        <= COMMIT;
                    load_ready_o <= 1'b0;
                end
                COMMIT: begin
                    wr_addr  <= wr_addr + 1'b1;
                    tile_cnt <= tile_next;
                    if (tile_next == count_q) begin
                        state <= DONE;
                    end else begin
                        state        <= FILL;
                        load_ready_o <= 1'b1;
                    end
                end
                DONE: begin
                    load_done_o <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset so it maps onto an SRAM macro; contents survive reset.
    always_ff @(posedge clk) begin
        if (state == COMMIT && wr_in_range) mem[wr_addr] <= packed_word;
    end

    // NOTE: non-blocking update of mem means a same-edge read samples the pre-write word.
    always_ff @(posedge clk) begin
        if (reset) begin
            weight_valid_o_1 <= 1'b0;
            weight_valid_o_2 <= 1'b0;
            weight_addr_o_1  <= '0;
            weight_addr_o_2  <= '0;
            weight_data_o_1  <= '0;
            weight_data_o_2  <= '0;
        end else begin
            weight_valid_o_1 <= weight_package_1_valid_i;
            weight_valid_o_2 <= weight_package_2_valid_i;
            if (weight_package_1_valid_i) begin
                weight_addr_o_1 <= weight_addr_i_1;
                weight_data_o_1 <= in_range_1 ? mem[weight_addr_i_1] : '0;
            end
            if (weight_package_2_valid_i) begin
                weight_addr_o_2 <= weight_addr_i_2;
                weight_data_o_2 <= in_range_2 ? mem[weight_addr_i_2] : '0;
            end
        end
    end
endmodule

// File: tb/tb_weight_buffer.sv
// Directed self-checking bench for weight_buffer: loads, dual reads, read-first, wrap,
// empty bursts, ignored starts and mid-burst reset.
module tb_weight_buffer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_start_i = 1'b0;
    logic [7:0]   load_base_addr_i = '0;
    logic [7:0]   load_count_i = '0;
    logic [11:0]  load_elem_i = '0;
    logic         load_valid_i = 1'b0;
    logic         load_ready_o, load_done_o;
    logic [7:0]   weight_addr_i_1 = '0, weight_addr_i_2 = '0;
    logic         weight_package_1_valid_i = 1'b0, weight_package_2_valid_i = 1'b0;
    logic [511:0] weight_data_o_1, weight_data_o_2;
    logic [7:0]   weight_addr_o_1, weight_addr_o_2;
    logic         weight_valid_o_1, weight_valid_o_2;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [511:0] exp_mem [256];

    weight_buffer dut (
        .clk(clk), .reset(reset),
        .load_start_i(load_start_i), .load_base_addr_i(load_base_addr_i),
        .load_count_i(load_count_i), .load_elem_i(load_elem_i),
        .load_valid_i(load_valid_i), .load_ready_o(load_ready_o), .load_done_o(load_done_o),
        .weight_addr_i_1(weight_addr_i_1), .weight_addr_i_2(weight_addr_i_2),
        .weight_package_1_valid_i(weight_package_1_valid_i),
        .weight_package_2_valid_i(weight_package_2_valid_i),
        .weight_data_o_1(weight_data_o_1), .weight_data_o_2(weight_data_o_2),
        .weight_addr_o_1(weight_addr_o_1), .weight_addr_o_2(weight_addr_o_2),
        .weight_valid_o_1(weight_valid_o_1), .weight_valid_o_2(weight_valid_o_2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (load_done_o) done_cnt++;

    function automatic logic [11:0] gen_elem(input int pat, input int t, input int k);
        int v;
        if (pat == 0) v = (t == 0) ? k + 1 : k - 36;
        else          v = pat * 97 + t * 41 + k * 7 - 1000;
        return v[11:0];
    endfunction

    function automatic logic [511:0] pack_word(input int pat, input int t);
        logic [511:0] w = '0;
        for (int k = 0; k < 36; k++) w[k*12 +: 12] = gen_elem(pat, t, k);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [7:0] base, input logic [7:0] cnt);
        load_base_addr_i = base;
        load_count_i     = cnt;
        load_start_i     = 1'b1;
        tick();
        load_start_i     = 1'b0;
    endtask

    // Holds valid high for n elements starting at k0; ticks counts cycles spent.
    task automatic feed_tile(input int pat, input int t, input int k0, input int n, output int ticks);
        int wait_n;
        ticks = 0;
        for (int k = k0; k < k0 + n; k++) begin
            load_elem_i  = gen_elem(pat, t, k);
            load_valid_i = 1'b1;
            wait_n = 0;
            while (!load_ready_o && wait_n < 50) begin
                tick();
                wait_n++;
                ticks++;
            end
            if (!load_ready_o) begin
                checks++; errors++;
                $display("FAIL feed_timeout: load_ready_o=%b required 1", load_ready_o);
                load_valid_i = 1'b0;
                return;
            end
            tick();
            ticks++;
        end
        load_valid_i = 1'b0;
    endtask

    // Samples load_done_o after the commit edge and the two following edges.
    task automatic finish_burst(output logic [2:0] seen);
        for (int i = 0; i < 3; i++) begin
            tick();
            seen[i] = load_done_o;
        end
    endtask

    task automatic do_read(input logic [7:0] a1, input logic r1, input logic [7:0] a2, input logic r2);
        weight_addr_i_1 = a1; weight_package_1_valid_i = r1;
        weight_addr_i_2 = a2; weight_package_2_valid_i = r2;
        tick();
        weight_package_1_valid_i = 1'b0;
        weight_package_2_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({load_ready_o, load_done_o, weight_valid_o_1, weight_valid_o_2} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000",
                     {load_ready_o, load_done_o, weight_valid_o_1, weight_valid_o_2});
        end
        checks++;
        if ({weight_data_o_1, weight_data_o_2, weight_addr_o_1, weight_addr_o_2} !== '0) begin
            errors++;
            $display("FAIL reset_data: data1=%h addr1=%h required 0", weight_data_o_1, weight_addr_o_1);
        end
    endtask

    task automatic test_load_read();
        int tk0, tk1;
        logic [2:0] seen;
        start_burst(8'd0, 8'd2);
        feed_tile(0, 0, 0, 36, tk0);
        feed_tile(0, 1, 0, 36, tk1);
        finish_burst(seen);
        exp_mem[0] = pack_word(0, 0);
        exp_mem[1] = pack_word(0, 1);
        checks++;
        if (tk1 !== 37) begin errors++; $display("FAIL tile_throughput: got %0d cycles required 37", tk1); end
        checks++;
        if (seen !== 3'b010) begin errors++; $display("FAIL load_done_pulse: got %b required 010", seen); end
        do_read(8'd0, 1'b1, 8'd1, 1'b1);
        checks++;
        if (weight_data_o_1[11:0] !== 12'd1) begin
            errors++; $display("FAIL t1_elem0: got %h required 001", weight_data_o_1[11:0]);
        end
        checks++;
        if (weight_data_o_1[431:420] !== 12'd36) begin
            errors++; $display("FAIL t1_elem35: got %h required 024", weight_data_o_1[431:420]);
        end
        checks++;
        if (weight_data_o_1[511:432] !== 80'd0) begin
            errors++; $display("FAIL t1_pad: got %h required 0", weight_data_o_1[511:432]);
        end
        checks++;
        if (weight_data_o_2[11:0] !== 12'hFDC) begin
            errors++; $display("FAIL t2_elem0: got %h required fdc", weight_data_o_2[11:0]);
        end
        checks++;
        if (weight_data_o_2 !== exp_mem[1]) begin
            errors++; $display("FAIL t2_word: got %h required %h", weight_data_o_2, exp_mem[1]);
        end
        checks++;
        if ({weight_valid_o_1, weight_valid_o_2, weight_addr_o_1, weight_addr_o_2} !== {2'b11, 8'd0, 8'd1}) begin
            errors++; $display("FAIL read_echo: valid=%b%b addr=%0d/%0d required 11 0/1",
                               weight_valid_o_1, weight_valid_o_2, weight_addr_o_1, weight_addr_o_2);
        end
    endtask

    task automatic test_dual_same_addr();
        int tk;
        logic [2:0] seen;
        start_burst(8'd4, 8'd2);
        feed_tile(1, 0, 0, 36, tk);
        feed_tile(1, 1, 0, 36, tk);
        finish_burst(seen);
        exp_mem[4] = pack_word(1, 0);
        exp_mem[5] = pack_word(1, 1);
        weight_addr_i_1 = 8'd5; weight_package_1_valid_i = 1'b1;
        weight_addr_i_2 = 8'd5; weight_package_2_valid_i = 1'b1;
        #1;
        checks++;
        if ({weight_valid_o_1, weight_valid_o_2} !== 2'b00) begin
            errors++; $display("FAIL dual_early_valid: got %b%b required 00", weight_valid_o_1, weight_valid_o_2);
        end
        tick();
        weight_package_1_valid_i = 1'b0;
        weight_package_2_valid_i = 1'b0;
        checks++;
        if ({weight_valid_o_1, weight_valid_o_2} !== 2'b11) begin
            errors++; $display("FAIL dual_valid: got %b%b required 11", weight_valid_o_1, weight_valid_o_2);
        end
        checks++;
        if (weight_data_o_1 !== exp_mem[5] || weight_data_o_2 !== exp_mem[5]) begin
            errors++; $display("FAIL dual_data: got %h / %h required %h", weight_data_o_1, weight_data_o_2, exp_mem[5]);
        end
        tick();
        checks++;
        if ({weight_valid_o_1, weight_valid_o_2} !== 2'b00 || weight_data_o_1 !== exp_mem[5]) begin
            errors++; $display("FAIL idle_hold: valid=%b%b data=%h required 00 and held",
                               weight_valid_o_1, weight_valid_o_2, weight_data_o_1);
        end
    endtask

    task automatic test_read_first();
        int tk;
        logic [2:0] seen;
        start_burst(8'd3, 8'd1);
        feed_tile(2, 0, 0, 36, tk);
        finish_burst(seen);
        exp_mem[3] = pack_word(2, 0);
        start_burst(8'd3, 8'd1);
        feed_tile(3, 0, 0, 36, tk);
        weight_addr_i_1 = 8'd3; weight_package_1_valid_i = 1'b1;
        tick();
        checks++;
        if (weight_data_o_1 !== exp_mem[3]) begin
            errors++; $display("FAIL read_first_old: got %h required %h", weight_data_o_1, exp_mem[3]);
        end
        exp_mem[3] = pack_word(3, 0);
        tick();
        weight_package_1_valid_i = 1'b0;
        checks++;
        if (weight_data_o_1 !== exp_mem[3]) begin
            errors++; $display("FAIL read_first_new: got %h required %h", weight_data_o_1, exp_mem[3]);
        end
        checks++;
        if (load_done_o !== 1'b1) begin errors++; $display("FAIL read_first_done: got %b required 1", load_done_o); end
        tick();
    endtask

    task automatic test_wrap();
        int tk, d0;
        logic [2:0] seen;
        d0 = done_cnt;
        start_burst(8'd255, 8'd2);
        feed_tile(4, 0, 0, 36, tk);
        feed_tile(4, 1, 0, 36, tk);
        finish_burst(seen);
        exp_mem[255] = pack_word(4, 0);
        exp_mem[0]   = pack_word(4, 1);
        checks++;
        if (seen !== 3'b010 || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL wrap_done: got %b count %0d required 010 count 1", seen, done_cnt - d0);
        end
        do_read(8'd255, 1'b1, 8'd0, 1'b1);
        checks++;
        if (weight_data_o_1 !== exp_mem[255] || weight_data_o_2 !== exp_mem[0]) begin
            errors++; $display("FAIL wrap_data: got %h / %h required %h / %h",
                               weight_data_o_1, weight_data_o_2, exp_mem[255], exp_mem[0]);
        end
    endtask

    task automatic test_zero_count_and_ignored_start();
        int tk;
        logic [2:0] seen;
        logic [1:0] rd;
        start_burst(8'd4, 8'd0);
        rd = {load_ready_o, load_done_o};
        tick();
        checks++;
        if (rd !== 2'b00 || {load_ready_o, load_done_o} !== 2'b01) begin
            errors++; $display("FAIL zero_count_done: got %b then %b required 00 then 01", rd, {load_ready_o, load_done_o});
        end
        tick();
        checks++;
        if (load_done_o !== 1'b0) begin errors++; $display("FAIL zero_count_single: got %b required 0", load_done_o); end
        do_read(8'd4, 1'b1, 8'd5, 1'b1);
        checks++;
        if (weight_data_o_1 !== exp_mem[4] || weight_data_o_2 !== exp_mem[5]) begin
            errors++; $display("FAIL zero_count_mem: got %h required %h", weight_data_o_1, exp_mem[4]);
        end
        start_burst(8'd20, 8'd1);
        feed_tile(5, 0, 0, 10, tk);
        start_burst(8'd40, 8'd3);
        checks++;
        if (load_ready_o !== 1'b1) begin errors++; $display("FAIL ignored_start_ready: got %b required 1", load_ready_o); end
        feed_tile(5, 0, 10, 26, tk);
        finish_burst(seen);
        exp_mem[20] = pack_word(5, 0);
        checks++;
        if (seen !== 3'b010 || load_ready_o !== 1'b0) begin
            errors++; $display("FAIL ignored_start_done: got %b ready %b required 010 ready 0", seen, load_ready_o);
        end
        do_read(8'd20, 1'b1, 8'd0, 1'b0);
        checks++;
        if (weight_data_o_1 !== exp_mem[20]) begin
            errors++; $display("FAIL ignored_start_data: got %h required %h", weight_data_o_1, exp_mem[20]);
        end
    endtask

    task automatic test_reset_mid_burst();
        int tk, d0;
        logic [2:0] seen;
        start_burst(8'd50, 8'd2);
        feed_tile(6, 0, 0, 20, tk);
        d0 = done_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({load_ready_o, load_done_o, weight_valid_o_1, weight_valid_o_2} !== 4'b0 ||
            weight_data_o_1 !== '0 || weight_addr_o_1 !== '0) begin
            errors++; $display("FAIL midreset_outputs: ctrl=%b data1=%h required 0",
                               {load_ready_o, load_done_o, weight_valid_o_1, weight_valid_o_2}, weight_data_o_1);
        end
        repeat (40) tick();
        checks++;
        if (done_cnt !== d0 || load_ready_o !== 1'b0) begin
            errors++; $display("FAIL midreset_nodone: pulses %0d ready %b required 0 and 0", done_cnt - d0, load_ready_o);
        end
        start_burst(8'd60, 8'd1);
        feed_tile(7, 0, 0, 36, tk);
        finish_burst(seen);
        exp_mem[60] = pack_word(7, 0);
        checks++;
        if (seen !== 3'b010) begin errors++; $display("FAIL midreset_reload_done: got %b required 010", seen); end
        do_read(8'd60, 1'b1, 8'd255, 1'b1);
        checks++;
        if (weight_data_o_1 !== exp_mem[60] || weight_data_o_2 !== exp_mem[255]) begin
            errors++; $display("FAIL midreset_reload_data: got %h / %h required %h / %h",
                               weight_data_o_1, weight_data_o_2, exp_mem[60], exp_mem[255]);
        end
        do_read(8'd4, 1'b1, 8'd0, 1'b1);
        checks++;
        if (weight_data_o_1 !== exp_mem[4] || weight_data_o_2 !== exp_mem[0]) begin
            errors++; $display("FAIL midreset_kept: got %h / %h required %h / %h",
                               weight_data_o_1, weight_data_o_2, exp_mem[4], exp_mem[0]);
        end
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_dual_same_addr();
        test_read_first();
        test_wrap();
        test_zero_count_and_ignored_start();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
